// File: rtl/cpu_bus_responder_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_responder_pkg
// Shared definitions for the CPU bus responder and its register file:
//   - state_e           : responder FSM state encoding
//   - DEFAULT_BASE_ADDR : default address of register 0
//   - DEFAULT_NREGS     : default number of 8-bit registers
// ---------------------------------------------------------------------------
package cpu_bus_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h10;
    localparam int         DEFAULT_NREGS     = 16;

endpackage

// File: rtl/cpu_bus_regfile.sv
// ---------------------------------------------------------------------------
// cpu_bus_regfile
// Register array with address decode, synchronous write and registered read.
// Optional feature macro: CPU_BUS_RESPONDER_PARITY_EN (even parity per word).
// Ports:
//   clk, reset    : clock, synchronous active-high reset (clears all words)
//   cap_i         : access capture strobe; loads the read register
//   rd_i          : captured access is a plain read
//   wr_en_i       : captured access is a plain write
//   addr_i        : byte address
//   wdata_i       : write data
//   par_inv_i     : (parity build) invert the parity bit stored on writes
//   par_err_o     : (parity build) registered parity mismatch of the last read
//   rdata_o       : registered read data (00 for non-reads / out of window)
//   in_win_o      : combinational decode, addr_i is inside the window
// ---------------------------------------------------------------------------
module cpu_bus_regfile
    import cpu_bus_responder_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int         NREGS     = DEFAULT_NREGS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cap_i,
    input  logic       rd_i,
    input  logic       wr_en_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
`ifdef CPU_BUS_RESPONDER_PARITY_EN
    input  logic       par_inv_i,
    output logic       par_err_o,
`endif
    output logic [7:0] rdata_o,
    output logic       in_win_o
);

    localparam logic [8:0] NREGS_W = 9'(NREGS);

    // The subtraction is 8-bit unsigned; the explicit >= test keeps addresses
    // below the base from wrapping into the window.
    logic [7:0] idx;
    assign idx      = addr_i - BASE_ADDR;
    assign in_win_o = (addr_i >= BASE_ADDR) && ({1'b0, idx} < NREGS_W);

    logic [NREGS*8-1:0] mem_flat;
    logic [NREGS-1:0]   par_flat;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [7:0] word_q;
            logic       par_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_q <= 8'h00;
                    par_q  <= 1'b0;
                end else if (wr_en_i && in_win_o && (idx == 8'(gi))) begin
                    word_q <= wdata_i;
`ifdef CPU_BUS_RESPONDER_PARITY_EN
                    par_q  <= (^wdata_i) ^ par_inv_i;
`else
                    par_q  <= 1'b0;
`endif
                end
            end
            assign mem_flat[gi*8 +: 8] = word_q;
            assign par_flat[gi]        = par_q;
        end
    endgenerate

    logic [7:0] rd_word;
    logic       rd_par;
    always_comb begin
        rd_word = 8'h00;
        rd_par  = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == 8'(i)) begin
                rd_word = mem_flat[i*8 +: 8];
                rd_par  = par_flat[i];
            end
        end
    end

    logic [7:0] rdata_q, rdata_d;
    logic       par_err_q, par_err_d;
    logic       rd_hit;

    assign rd_hit    = rd_i && in_win_o;
    assign rdata_d   = cap_i ? (rd_hit ? rd_word : 8'h00) : rdata_q;
    assign par_err_d = cap_i ? (rd_hit && (rd_par != (^rd_word))) : par_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q   <= 8'h00;
            par_err_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            par_err_q <= par_err_d;
        end
    end

    assign rdata_o = rdata_q;
`ifdef CPU_BUS_RESPONDER_PARITY_EN
    assign par_err_o = par_err_q;
`endif

endmodule

// File: rtl/cpu_bus_responder.sv
// ---------------------------------------------------------------------------
// cpu_bus_responder
// Single-cycle-ack register responder for a simple CPU-side bus.
// Optional feature macro: CPU_BUS_RESPONDER_PARITY_EN (adds par_inv port and
// parity errors on read).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   ce, rd, wr : chip enable and read/write strobes (strobes qualified by ce)
//   addr       : byte address
//   data_wr    : write data
//   par_inv    : (parity build) invert stored parity on writes
//   data_rd    : read data, valid in RESP/HOLD, 00 in IDLE
//   ack        : one-cycle completion pulse
//   err        : qualifies ack, access rejected
// ---------------------------------------------------------------------------
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int         NREGS     = DEFAULT_NREGS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] data_wr,
`ifdef CPU_BUS_RESPONDER_PARITY_EN
    input  logic       par_inv,
`endif
    output logic [7:0] data_rd,
    output logic       ack,
    output logic       err
);

    state_e state_q, state_d;
    logic   capture;
    logic   in_win;
    logic   err_q, err_d;
    logic [7:0] rdata;

    // Only IDLE accepts a new access; RESP/HOLD ignore all strobes.
    assign capture = (state_q == ST_IDLE) && ce && (rd || wr);
    assign err_d   = capture ? ((rd && wr) || !in_win) : err_q;

`ifdef CPU_BUS_RESPONDER_PARITY_EN
    logic par_err;
`else
    localparam logic par_err = 1'b0;
`endif

    cpu_bus_regfile #(
        .BASE_ADDR (BASE_ADDR),
        .NREGS     (NREGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .cap_i     (capture),
        .rd_i      (rd && !wr),
        .wr_en_i   (capture && wr && !rd),
        .addr_i    (addr),
        .wdata_i   (data_wr),
`ifdef CPU_BUS_RESPONDER_PARITY_EN
        .par_inv_i (par_inv),
        .par_err_o (par_err),
`endif
        .rdata_o   (rdata),
        .in_win_o  (in_win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        err     = 1'b0;
        data_rd = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (capture) state_d = ST_RESP;
            end
            ST_RESP: begin
                ack     = 1'b1;
                err     = err_q || par_err;
                data_rd = rdata;
                state_d = ce ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                // Read data stays stable until ce is released.
                data_rd = rdata;
                if (!ce) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

    localparam int BASE  = 8'h10;
    localparam int NREGS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce, rd, wr;
    logic [7:0] addr, data_wr;
    logic [7:0] data_rd;
    logic       ack, err;
`ifdef CPU_BUS_RESPONDER_PARITY_EN
    logic       par_inv;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [NREGS];

    cpu_bus_responder dut (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .data_wr (data_wr),
`ifdef CPU_BUS_RESPONDER_PARITY_EN
        .par_inv (par_inv),
`endif
        .data_rd (data_rd),
        .ack     (ack),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         r;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        bit         e;
        logic [7:0] q;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp_v);
        end
    endtask

    function automatic bit model_inwin(input logic [7:0] a);
        int ai;
        ai = int'(a);
        return (ai >= BASE) && (ai - BASE < NREGS);
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (!model_inwin(a)) return 8'h00;
        return model_mem[int'(a) - BASE];
    endfunction

    task automatic model_apply(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        if (w && !r && model_inwin(a)) model_mem[int'(a) - BASE] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model_mem[i] = 8'h00;
    endtask

    // One complete access: capture, RESP check, release ce, IDLE check.
    task automatic access(input string tag, input bit r, input bit w,
                          input logic [7:0] a, input logic [7:0] d,
                          input bit exp_err, input logic [7:0] exp_data);
        @(negedge clk);
        ce = 1'b1; rd = r; wr = w; addr = a; data_wr = d;
        @(negedge clk);
        $display("access %s rd=%0b wr=%0b addr=%02h wdata=%02h -> ack=%0b err=%0b data_rd=%02h",
                 tag, r, w, a, d, ack, err, data_rd);
        check({tag, " ack"}, {7'b0, ack}, 8'd1);
        check({tag, " err"}, {7'b0, err}, {7'b0, exp_err});
        if (r && !w) check({tag, " data_rd"}, data_rd, exp_data);
        ce = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = 8'($urandom); data_wr = 8'($urandom);
        @(negedge clk);
        check({tag, " idle ack"}, {7'b0, ack}, 8'd0);
        check({tag, " idle data_rd"}, data_rd, 8'h00);
    endtask

    initial begin
        int acks;
        logic err_seen;

        reset = 1'b1; ce = 1'b0; rd = 1'b0; wr = 1'b0; addr = 8'h00; data_wr = 8'h00;
`ifdef CPU_BUS_RESPONDER_PARITY_EN
        par_inv = 1'b0;
`endif
        model_clear();

        vecs[0]  = '{1'b0, 1'b1, 8'h11, 8'hAA, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 8'hAA};
        vecs[2]  = '{1'b0, 1'b1, 8'h12, 8'hAB, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 8'h13, 8'h0A, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'hAB};
        vecs[5]  = '{1'b1, 1'b0, 8'h13, 8'h00, 1'b0, 8'h0A};
        vecs[6]  = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 8'hAA};
        vecs[7]  = '{1'b1, 1'b0, 8'h0F, 8'h00, 1'b1, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 8'h20, 8'h55, 1'b1, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 8'h1F, 8'h77, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 1'b0, 8'h1F, 8'h00, 1'b0, 8'h77};
        vecs[13] = '{1'b1, 1'b1, 8'h11, 8'h33, 1'b1, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 8'hAA};
        vecs[15] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset ack", {7'b0, ack}, 8'd0);
        check("reset err", {7'b0, err}, 8'd0);
        check("reset data_rd", data_rd, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset ack", {7'b0, ack}, 8'd0);

        // Directed table
        for (int i = 0; i < 16; i++) begin
            access($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d,
                   vecs[i].e, vecs[i].q);
            model_apply(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
        end

        // ce high without strobes stays idle; a strobe later is captured
        @(negedge clk);
        ce = 1'b1; rd = 1'b0; wr = 1'b0; addr = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no-strobe ack", {7'b0, ack}, 8'd0);
        end
        rd = 1'b1;
        @(negedge clk);
        check("late-strobe ack", {7'b0, ack}, 8'd1);
        check("late-strobe data_rd", data_rd, 8'hAA);
        ce = 1'b0; rd = 1'b0;
        @(negedge clk);

        // rd=wr=1, then ce held high: exactly one ack, no recapture
        @(negedge clk);
        ce = 1'b1; rd = 1'b1; wr = 1'b1; addr = 8'h11; data_wr = 8'h33;
        acks = 0; err_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                err_seen = err;
            end
            rd = 1'($urandom); wr = 1'($urandom); addr = 8'($urandom);
        end
        check("hold ack count", 8'(acks), 8'd1);
        check("hold both-strobe err", {7'b0, err_seen}, 8'd1);
        ce = 1'b0; rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        access("after-hold read", 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 8'hAA);

        // Randomised accesses against the model
        for (int n = 0; n < 40; n++) begin
            int sel;
            bit r, w, inw;
            logic [7:0] a, d;
            sel = int'($urandom_range(0, 9));
            r = (sel == 0) || (sel < 5);
            w = (sel == 0) || (sel >= 5);
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h0C, 8'h22));
            d = 8'($urandom);
            inw = model_inwin(a);
            access($sformatf("rand%0d", n), r, w, a, d, (r && w) || !inw,
                   (r && !w) ? model_read(a) : 8'h00);
            model_apply(r, w, a, d);
        end

        // Reset while an access is presented; access still pending is taken as new
        @(negedge clk);
        reset = 1'b1; ce = 1'b1; rd = 1'b1; wr = 1'b0; addr = 8'h12;
        @(negedge clk);
        check("reset-pending ack", {7'b0, ack}, 8'd0);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        check("recapture ack", {7'b0, ack}, 8'd1);
        check("recapture err", {7'b0, err}, 8'd0);
        check("recapture data_rd", data_rd, 8'h00);
        ce = 1'b0; rd = 1'b0;
        @(negedge clk);

        // Reset on the capture edge of a write discards it
        access("w55", 1'b0, 1'b1, 8'h14, 8'h55, 1'b0, 8'h00);
        model_apply(1'b0, 1'b1, 8'h14, 8'h55);
        @(negedge clk);
        reset = 1'b1; ce = 1'b1; rd = 1'b0; wr = 1'b1; addr = 8'h14; data_wr = 8'h66;
        @(negedge clk);
        check("reset-write ack", {7'b0, ack}, 8'd0);
        reset = 1'b0; ce = 1'b0; wr = 1'b0;
        model_clear();
        @(negedge clk);
        check("reset-write later ack", {7'b0, ack}, 8'd0);
        access("read14 after reset", 1'b1, 1'b0, 8'h14, 8'h00, 1'b0, model_read(8'h14));
        access("read1F after reset", 1'b1, 1'b0, 8'h1F, 8'h00, 1'b0, model_read(8'h1F));

`ifdef CPU_BUS_RESPONDER_PARITY_EN
        par_inv = 1'b1;
        access("par bad write", 1'b0, 1'b1, 8'h15, 8'h3C, 1'b0, 8'h00);
        par_inv = 1'b0;
        access("par bad read", 1'b1, 1'b0, 8'h15, 8'h00, 1'b1, 8'h3C);
        access("par good write", 1'b0, 1'b1, 8'h15, 8'h5D, 1'b0, 8'h00);
        access("par good read", 1'b1, 1'b0, 8'h15, 8'h00, 1'b0, 8'h5D);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 Parameter BASE_ADDR, default 8'h10: address of register 0; the window is BASE_ADDR .. BASE_ADDR+NREGS-1.
REQ-002 Parameter NREGS, default 16: number of 8-bit registers, range 1..16.
REQ-003 Port clk, input, 1: single clock; all state changes on the posedge.
REQ-004 Port reset, input, 1: synchronous, active-high reset, sampled on the clk posedge.
REQ-005 Port ce, input, 1: chip enable from the CPU-side initiator.
REQ-006 Port rd, input, 1: read strobe, qualified by ce.
REQ-007 Port wr, input, 1: write strobe, qualified by ce.
REQ-008 Port addr, input, 8: byte address.
REQ-009 Port data_wr, input, 8: write data.
REQ-010 Port data_rd, output, 8: registered read data.
REQ-011 Port ack, output, 1: one-cycle pulse that completes the access.
REQ-012 Port err, output, 1: qualifies ack; the access was rejected.

Function
REQ-013 The FSM SHALL have three states: IDLE, RESP and HOLD.
REQ-014 IDLE: on a posedge with ce=1 and rd^wr=1, the FSM SHALL capture addr and data_wr and go to RESP.
REQ-015 Access request on a posedge with ce=1 and rd=wr=1: the FSM SHALL go to RESP with err flagged; no register is written.
REQ-016 Posedge with ce=1 and rd=wr=0: the FSM SHALL stay in IDLE.
REQ-017 Write (capture edge in IDLE): the addressed register SHALL update on that capture edge when the address is in the window; the write is therefore visible to a read captured one cycle later.
REQ-018 Read: data_rd SHALL carry the register value from the cycle after the capture edge (latency 1).
REQ-019 Read hold: data_rd SHALL hold that value through RESP and HOLD, and SHALL be 8'h00 in IDLE.
REQ-020 RESP: ack=1 for exactly one cycle; err=1 in that cycle if the address is out of window or rd=wr=1, else err=0.
REQ-021 Out-of-window read: data_rd SHALL be 8'h00.
REQ-022 Out-of-window write: the write SHALL be discarded.
REQ-023 RESP SHALL go to HOLD when ce=1 and to IDLE when ce=0.
REQ-024 HOLD SHALL stay in HOLD while ce=1 and go to IDLE when ce=0; a new access requires ce to be released for at least one cycle first.
REQ-025 Strobe or address changes during RESP or HOLD SHALL be ignored.
REQ-026 Address decode: index = addr - BASE_ADDR, 8-bit unsigned; the address is in window if and only if addr >= BASE_ADDR and the index < NREGS. No wrap-around past 8'hFF.
REQ-027 Maximum throughput SHALL be one access per 3 cycles (capture, RESP, ce-low cycle).

Reset
REQ-028 When reset=1: FSM goes to IDLE, data_rd=8'h00, ack=0, err=0, all registers cleared to 8'h00.
REQ-029 Reset SHALL take priority over any access.
REQ-030 Reset mid-access SHALL abort the access with no ack; a write captured on the same edge as reset SHALL be discarded.
REQ-031 After reset deasserts, an access already in progress (ce still high) SHALL be captured as new, since the FSM is in IDLE.

Configuration
REQ-032 Macro CPU_BUS_RESPONDER_PARITY_EN: when defined, each register SHALL store an even-parity bit computed on write.
REQ-033 With the macro defined, a read whose stored parity mismatches SHALL return the stored data with err=1 on ack.
REQ-034 With the macro defined, a stuck-parity test hook input par_inv (1 bit) SHALL invert the parity stored on writes.
REQ-035 With the macro undefined: no parity storage, no par_inv port, and err SHALL reflect only decode and strobe errors.

Structure
REQ-036 A shared package/include SHALL hold the state encodings (IDLE=2'd0, RESP=2'd1, HOLD=2'd2) and the default BASE_ADDR and NREGS constants.
REQ-037 The register array and its decode SHALL live in sub-module cpu_bus_regfile (synchronous write, registered read).
REQ-038 The FSM and the ack/err logic SHALL stay in the top module.

Verification
REQ-039 Write 8'hAA to 8'h11, release ce, then read 8'h11 -> ack one cycle after each capture, err=0, data_rd=8'hAA.
REQ-040 Write 8'hAB to 8'h12 and 8'h0A to 8'h13, read both back -> 8'hAB and 8'h0A; register 8'h11 unchanged.
REQ-041 Read 8'h0F and 8'h20 -> ack with err=1, data_rd=8'h00; a write to 8'h20 leaves all registers unchanged.
REQ-042 ce=1 with rd=wr=1 at 8'h11 -> ack with err=1, register unchanged; then hold ce high for 5 cycles -> exactly one ack, no recapture.
REQ-043 Write 8'h55 to 8'h14, then assert reset on the capture edge of a second write of 8'h66 to 8'h14 -> no ack; read 8'h14 returns 8'h00.
REQ-044 With CPU_BUS_RESPONDER_PARITY_EN: write with par_inv=1, then read -> stored data returned, err=1; with par_inv=0 -> err=0.
